// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RV32 definitions for the fetch stage.
// Contents: RV32_XLEN, RV32_NOP (addi x0,x0,0), the fetch_entry_t buffer entry type
// and a word-alignment helper.
package instruction_fetch_unit_pkg;

    localparam int unsigned RV32_XLEN = 32;
    localparam logic [31:0] RV32_NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [RV32_XLEN-1:0] instr;
        logic [RV32_XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [RV32_XLEN-1:0] word_align(input logic [RV32_XLEN-1:0] addr);
        return {addr[RV32_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle around the fetch stage: redirect input from execute, the instruction-memory
// request/response channel and the valid/ready instruction channel towards decode.
// Modports: master = fetch unit, slave = its environment (execute, imem, decode).
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic                 redirect_valid;
    logic [RV32_XLEN-1:0] redirect_pc;
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [RV32_XLEN-1:0] imem_req_addr;
    logic                 imem_resp_valid;
    logic [RV32_XLEN-1:0] imem_resp_data;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [RV32_XLEN-1:0] instruction;
    logic [RV32_XLEN-1:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output instr_valid, instruction, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  instr_valid, instruction, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with push, pop, flush and occupancy outputs.
// Ports: clk, rst_n (sync, active-low), push_i/push_data_i, pop_i, flush_i,
//        head_o (registered head entry), count_o, empty_o, full_o.
// Flush wins over push/pop in the same cycle; push and pop together are both honoured.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [WIDTH-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           empty_o,
    output logic                           full_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A full FIFO can still accept a push when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues word fetches to instruction memory, buffers
// returned words and hands {instruction, pc} to decode.
// Ports: clk, rst_n (sync, active-low), bus (instruction_fetch_unit_if.master): redirect,
//        imem request/response and the decode valid/ready channel.
// Request slots are reserved up front (outstanding + buffered < FIFO_DEPTH), so a response
// always finds room in the buffer.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING+1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH+1);
    localparam int unsigned EW  = $bits(fetch_entry_t);

    logic [RV32_XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic [OW-1:0]        drop_cnt_q, drop_cnt_d;
    logic                 run_q;

    logic                 req_valid, req_fire, resp_fire;
    logic                 buf_push, buf_pop, buf_empty, buf_full;
    logic [FCW-1:0]       buf_count;
    logic [EW-1:0]        buf_head_raw;
    fetch_entry_t         buf_head, buf_push_entry;
    logic [RV32_XLEN-1:0] tag_head;
    logic                 tag_empty, tag_full;
    logic [OW-1:0]        tag_count;
    logic                 unused_sig;

    assign unused_sig = ^{tag_count, buf_full};

    always_comb begin
        // run_q delays the first request to the cycle after reset is released.
        req_valid = run_q
                    && ((32'(outstanding_q) + 32'(buf_count)) < FIFO_DEPTH)
                    && (32'(outstanding_q) < MAX_OUTSTANDING)
                    && !tag_full;
        req_fire  = req_valid && bus.imem_req_ready;
        // Responses with nothing outstanding are a protocol error and are ignored.
        resp_fire = bus.imem_resp_valid && !tag_empty;

        buf_push_entry       = '0;
        buf_push_entry.instr = bus.imem_resp_data;
        buf_push_entry.pc    = tag_head;
        buf_push = resp_fire && (drop_cnt_q == '0) && !bus.redirect_valid;
        buf_pop  = !buf_empty && bus.instr_ready && !bus.redirect_valid;

        outstanding_d = outstanding_q + OW'(req_fire) - OW'(resp_fire);

        drop_cnt_d = drop_cnt_q;
        if (resp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
        // Everything still in flight after this cycle belongs to the old stream.
        if (bus.redirect_valid) drop_cnt_d = outstanding_d;

        pc_d = pc_q;
        if (req_fire) pc_d = pc_q + 32'd4;
        if (bus.redirect_valid) pc_d = word_align(bus.redirect_pc);
    end

    assign buf_head = fetch_entry_t'(buf_head_raw);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = !buf_empty;
    assign bus.instruction    = buf_empty ? RV32_NOP : buf_head.instr;
    assign bus.instr_pc       = buf_empty ? '0 : buf_head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            run_q         <= 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (buf_push),
        .push_data_i (buf_push_entry),
        .pop_i       (buf_pop),
        .flush_i     (bus.redirect_valid),
        .head_o      (buf_head_raw),
        .count_o     (buf_count),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    // Tag queue keeps the PC of every in-flight request, stale ones included.
    fetch_fifo #(
        .WIDTH (RV32_XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (resp_fire),
        .flush_i     (1'b0),
        .head_o      (tag_head),
        .count_o     (tag_count),
        .empty_o     (tag_empty),
        .full_o      (tag_full)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] model_pc;
    mreq_t       memq [$];
    exp_t        exp_q [$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: sample at negedge, update memory model and scoreboard,
    // then drive the next memory response just after the posedge.
    task automatic tick();
        logic fire, pop, redir;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            memq.delete();
            exp_q.delete();
        end else begin
            fire  = bus.imem_req_valid && bus.imem_req_ready;
            pop   = bus.instr_valid && bus.instr_ready;
            redir = bus.redirect_valid;
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, model_pc);
            if (pop && !redir) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_instr", bus.instr_pc, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", bus.instruction, e.instr);
                    chk("instr_pc", bus.instr_pc, e.pc);
                end
            end
            if (bus.imem_resp_valid) void'(memq.pop_front());
            if (fire) begin
                memq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
                if (!redir) exp_q.push_back('{instr: memf(bus.imem_req_addr),
                                               pc: bus.imem_req_addr});
                model_pc = model_pc + 32'd4;
            end
            if (redir) begin
                model_pc = {bus.redirect_pc[31:2], 2'b00};
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memf(memq[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
        chk("valid_after_redirect", 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int waited;
        rst_n               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.instr_ready     = 1'b1;
        model_pc            = 32'h0;

        // Reset held three cycles.
        repeat (3) tick();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instruction", bus.instruction, NOP);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);

        rst_n    = 1'b1;
        model_pc = 32'h0;
        tick();
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        tick();
        chk("second_req_addr", bus.imem_req_addr, 32'h4);
        chk("early_instr_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("first_instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("first_instr_pc", bus.instr_pc, 32'h0);
        chk("first_instruction", bus.instruction, memf(32'h0));

        // Streaming with 1-cycle memory.
        repeat (20) tick();

        // Back-pressure: buffer fills, requests stop.
        bus.instr_ready = 1'b0;
        repeat (10) tick();
        chk("bp_instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("bp_exp_depth", 32'(exp_q.size()), 32'd2);
        bus.instr_ready = 1'b1;
        repeat (10) tick();

        // Redirect with latency-3 memory and requests in flight.
        lat = 3;
        repeat (8) tick();
        redirect_to(32'h0000_0103);
        waited = 0;
        while (!bus.imem_req_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("redir_req_addr", bus.imem_req_addr, 32'h0000_0100);
        waited = 0;
        while (!bus.instr_valid && waited < 30) begin
            tick();
            waited++;
        end
        chk("redir_first_valid", 32'(bus.instr_valid), 32'd1);
        chk("redir_first_pc", bus.instr_pc, 32'h0000_0100);
        repeat (20) tick();

        // Wrap with a held request.
        lat = 1;
        bus.imem_req_ready = 1'b0;
        repeat (8) tick();
        redirect_to(32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("held_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("wrap_req_addr", bus.imem_req_addr, 32'h0000_0000);
        repeat (20) tick();

        // Redirects during streaming at several phases, then back-to-back.
        for (int k = 0; k < 3; k++) begin
            repeat (k + 3) tick();
            redirect_to(32'h0000_4000 + 32'(k) * 32'h100);
        end
        repeat (5) tick();
        redirect_to(32'h0000_2000);
        redirect_to(32'h0000_3002);
        waited = 0;
        while (!bus.instr_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("b2b_first_pc", bus.instr_pc, 32'h0000_3000);
        repeat (20) tick();

        // Drain: stop requests, let everything come back and be consumed.
        bus.imem_req_ready = 1'b0;
        waited = 0;
        while ((exp_q.size() > 0 || memq.size() > 0) && waited < 40) begin
            tick();
            waited++;
        end
        tick();
        chk("drain_exp_left", 32'(exp_q.size()), 32'd0);
        chk("drain_instr_valid", 32'(bus.instr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
